id_npc_ctrl: RTL and testbench
==============================

Name: id_npc_ctrl

Overview:
- Decode-side partner of the instruction-fetch stage.
- Captures the fetched IR/PC4 into the IF/ID pipeline register and decodes branches and jumps (beq, bne, j, jal, jr) in the ID stage.
- Drives Npc, PCSrc and Stall back to the fetch stage; detects hazards and counts stall and taken-branch events.

Parameters:
- RESET_PC4, 32'h00003004, value loaded into PC4_D on reset (fetch start 0x3000 plus 4).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- IR_F  input  32  instruction from fetch
- PC4_F  input  32  fetch PC+4
- RS_data  input  32  register-file read of IR_D[25:21]
- RT_data  input  32  register-file read of IR_D[20:16]
- RegWrite_E  input  1  EX-stage instruction writes a register
- MemToReg_E  input  1  EX-stage instruction is a load
- WriteReg_E  input  5  EX-stage destination register
- MemToReg_M  input  1  MEM-stage instruction is a load
- WriteReg_M  input  5  MEM-stage destination register
- IR_D  output  32  IF/ID instruction register
- PC4_D  output  32  IF/ID PC+4 register
- Npc  output  32  redirect target to fetch
- PCSrc  output  1  1 = fetch loads Npc
- Stall  output  1  freeze fetch PC and IF/ID; also the bubble request for ID/EX
- stall_cnt  output  CNT_W  cycles with Stall=1
- taken_cnt  output  CNT_W  redirects issued

Behaviour:
- Reset (reset=0, asynchronous): IR_D=0 (nop), PC4_D=RESET_PC4, stall_cnt=0, taken_cnt=0. Combinational outputs then evaluate to PCSrc=0, Stall=0, Npc=0.
- IF/ID register update on posedge clk:
  - Stall=1: hold IR_D and PC4_D.
  - Otherwise: IR_D<=IR_F, PC4_D<=PC4_F (see the optional feature for flush).
- Decode from IR_D:
  - op=IR_D[31:26], rs=[25:21], rt=[20:16].
  - beq op=000100; bne op=000101; j op=000010; jal op=000011.
  - jr: op=000000 and funct [5:0]=001000.
- Npc (combinational, 32-bit, wraps modulo 2^32):
  - beq/bne: PC4_D + (sign-extend(IR_D[15:0]) << 2).
  - j/jal: {PC4_D[31:28], IR_D[25:0], 2'b00}.
  - jr: RS_data.
  - Any other instruction: 0.
- Taken condition: beq and RS_data==RT_data; bne and RS_data!=RT_data; j, jal and jr are always taken.
- Source usage:
  - rs used by every opcode except j, jal, lui (001111).
  - rt used by R-type (op 000000), sw (101011), beq, bne.
  - Branch sources: rs and rt for beq/bne; rs only for jr.
- Stall = 1 if any of the following holds (register 0 never causes a stall):
  - (a) MemToReg_E and WriteReg_E!=0 and WriteReg_E equals a used source.
  - (b) IR_D is beq/bne/jr, RegWrite_E, WriteReg_E!=0, and WriteReg_E equals a branch source.
  - (c) IR_D is beq/bne/jr, MemToReg_M, WriteReg_M!=0, and WriteReg_M equals a branch source.
- PCSrc = taken and !Stall. A redirect is never issued while stalled, so the branch re-evaluates the next cycle with fresh operands.
- Delay slot (default build): the instruction after a branch always executes. No flush.
- Counters:
  - stall_cnt increments on each posedge with Stall=1.
  - taken_cnt increments on each posedge with PCSrc=1.
  - Both wrap at 2^CNT_W.
- Stall and a taken branch in the same cycle: Stall wins; PCSrc=0; taken_cnt is not incremented.
- Reset asserted mid-stall: registers clear immediately and Stall drops once the decode sees the nop.

Optional Feature:
- Macro: ID_FLUSH_ON_TAKEN_EN.
- Defined: no delay slot. On a posedge with PCSrc=1 and Stall=0, IR_D<=0 (nop) and PC4_D<=PC4_F, squashing the wrong-path fetch.
- Not defined: delay-slot semantics as above; IR_D always loads IR_F when not stalled.

Test Plan:
- Release reset, IR_F=0x10220003, PC4_F=0x3008; next cycle RS_data=RT_data=5, no hazards -> IR_D=0x10220003, PCSrc=1, Npc=0x00003014, taken_cnt=1 one cycle later.
- Same beq with RS_data=5, RT_data=6 -> PCSrc=0. Then bne 0x14220003 with the same data -> PCSrc=1, Npc=0x3014.
- IR_D=0x08000C01, PC4_D=0x3010 -> PCSrc=1, Npc=0x00003004. IR_D=0x03E00008, RS_data=0x3040 -> Npc=0x3040.
- Load-use: IR_D=0x00221820 (add $3,$1,$2), MemToReg_E=1, WriteReg_E=1 -> Stall=1, IR_D held, stall_cnt+1. Next cycle with MemToReg_E=0 -> Stall=0. Repeat with WriteReg_E=0 -> Stall=0.
- Branch hazard: IR_D=beq $1,$2 with RegWrite_E=1, WriteReg_E=2 -> Stall=1, PCSrc=0 despite equal operands. Then MemToReg_M=1, WriteReg_M=1 -> Stall=1. Then clear -> PCSrc=1.
- Drop reset mid-stall -> IR_D=0, PC4_D=0x3004, counters=0 asynchronously. With ID_FLUSH_ON_TAKEN_EN, a taken beq gives IR_D=0 on the next edge.

Source files
------------

// File: rtl/id_npc_ctrl.sv
// ID-stage branch/jump resolver: holds the IF/ID register, computes the fetch redirect and hazard stall.
// Optional macro ID_FLUSH_ON_TAKEN_EN squashes the delay-slot fetch on a taken redirect.
module id_npc_ctrl #(
  parameter logic [31:0] RESET_PC4 = 32'h00003004,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_F,
  input  logic [31:0]      PC4_F,
  input  logic [31:0]      RS_data,
  input  logic [31:0]      RT_data,
  input  logic             RegWrite_E,
  input  logic             MemToReg_E,
  input  logic [4:0]       WriteReg_E,
  input  logic             MemToReg_M,
  input  logic [4:0]       WriteReg_M,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC4_D,
  output logic [31:0]      Npc,
  output logic             PCSrc,
  output logic             Stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        is_beq;
  logic        is_bne;
  logic        is_jmp;
  logic        is_jr;
  logic        is_cond;
  logic        is_br;
  logic        rs_used;
  logic        rt_used;
  logic        hz_load_use;
  logic        hz_br_e;
  logic        hz_br_m;
  logic        taken;
  logic [31:0] br_off;

  assign op    = IR_D[31:26];
  assign rs    = IR_D[25:21];
  assign rt    = IR_D[20:16];
  assign funct = IR_D[5:0];

  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_jmp  = (op == OP_J) || (op == OP_JAL);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_cond = is_beq || is_bne;
  assign is_br   = is_cond || is_jr;

  assign rs_used = !is_jmp && (op != OP_LUI);
  assign rt_used = (op == OP_RTYPE) || (op == OP_SW) || is_cond;

  // Destination register 0 is hardwired, so it never creates a dependency.
  assign hz_load_use = MemToReg_E && (WriteReg_E != 5'd0) &&
                       ((rs_used && (WriteReg_E == rs)) || (rt_used && (WriteReg_E == rt)));
  assign hz_br_e     = is_br && RegWrite_E && (WriteReg_E != 5'd0) &&
                       ((WriteReg_E == rs) || (is_cond && (WriteReg_E == rt)));
  assign hz_br_m     = is_br && MemToReg_M && (WriteReg_M != 5'd0) &&
                       ((WriteReg_M == rs) || (is_cond && (WriteReg_M == rt)));

  assign Stall = hz_load_use || hz_br_e || hz_br_m;

  assign br_off = {{14{IR_D[15]}}, IR_D[15:0], 2'b00};

  always_comb begin
    Npc   = 32'd0;
    taken = 1'b0;
    if (is_cond) begin
      Npc   = PC4_D + br_off;
      taken = is_beq ? (RS_data == RT_data) : (RS_data != RT_data);
    end else if (is_jmp) begin
      Npc   = {PC4_D[31:28], IR_D[25:0], 2'b00};
      taken = 1'b1;
    end else if (is_jr) begin
      Npc   = RS_data;
      taken = 1'b1;
    end
  end

  // A stalled branch must not redirect: its operands may still be stale.
  assign PCSrc = taken && !Stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IR_D  <= 32'd0;
      PC4_D <= RESET_PC4;
    end else if (!Stall) begin
`ifdef ID_FLUSH_ON_TAKEN_EN
      IR_D  <= PCSrc ? 32'd0 : IR_F;
`else
      IR_D  <= IR_F;
`endif
      PC4_D <= PC4_F;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (Stall) stall_cnt <= stall_cnt + CNT_ONE;
      if (PCSrc) taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_npc_ctrl.sv
// Scoreboard bench for id_npc_ctrl: directed test-plan steps followed by random instruction streams,
// checked against an instruction-level reference model.
module tb_id_npc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR_F = '0, PC4_F = '0, RS_data = '0, RT_data = '0;
  logic        RegWrite_E = 1'b0, MemToReg_E = 1'b0, MemToReg_M = 1'b0;
  logic [4:0]  WriteReg_E = '0, WriteReg_M = '0;
  logic [31:0] IR_D, PC4_D, Npc;
  logic        PCSrc, Stall;
  logic [15:0] stall_cnt, taken_cnt;

  id_npc_ctrl dut (
    .clk(clk), .reset(reset), .IR_F(IR_F), .PC4_F(PC4_F),
    .RS_data(RS_data), .RT_data(RT_data),
    .RegWrite_E(RegWrite_E), .MemToReg_E(MemToReg_E), .WriteReg_E(WriteReg_E),
    .MemToReg_M(MemToReg_M), .WriteReg_M(WriteReg_M),
    .IR_D(IR_D), .PC4_D(PC4_D), .Npc(Npc), .PCSrc(PCSrc), .Stall(Stall),
    .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ir_d;
    logic [31:0] pc4_d;
    logic [31:0] npc;
    logic        pcsrc;
    logic        stall;
    logic [15:0] sc;
    logic [15:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // Reference state: what the IF/ID register and counters should hold now.
  logic [31:0] m_ir  = 32'd0;
  logic [31:0] m_pc4 = 32'h00003004;
  logic [15:0] m_sc  = 16'd0;
  logic [15:0] m_tc  = 16'd0;

  function automatic void model_eval(
    input  logic [31:0] ir, pc4, rsd, rtd,
    input  logic rw_e, mr_e, input logic [4:0] wr_e,
    input  logic mr_m, input logic [4:0] wr_m,
    output logic [31:0] npc, output logic pcsrc, output logic stall);
    int op, fn, rs, rt, off;
    int srcs[$];
    int bsrcs[$];
    bit taken;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rs = int'(ir[25:21]); rt = int'(ir[20:16]);
    off = $signed(ir[15:0]);
    npc = 32'd0; taken = 0;
    if (op == 4 || op == 5) begin
      npc   = pc4 + 32'(off * 4);
      taken = (op == 4) ? (rsd == rtd) : (rsd != rtd);
      bsrcs.push_back(rs); bsrcs.push_back(rt);
    end else if (op == 2 || op == 3) begin
      npc   = (pc4 & 32'hF000_0000) | ({6'd0, ir[25:0]} * 4);
      taken = 1;
    end else if (op == 0 && fn == 8) begin
      npc   = rsd;
      taken = 1;
      bsrcs.push_back(rs);
    end
    if (op != 2 && op != 3 && op != 15) srcs.push_back(rs);
    if (op == 0 || op == 43 || op == 4 || op == 5) srcs.push_back(rt);
    stall = 0;
    foreach (srcs[i])
      if (mr_e && wr_e != 0 && srcs[i] == int'(wr_e)) stall = 1;
    foreach (bsrcs[i]) begin
      if (rw_e && wr_e != 0 && bsrcs[i] == int'(wr_e)) stall = 1;
      if (mr_m && wr_m != 0 && bsrcs[i] == int'(wr_m)) stall = 1;
    end
    pcsrc = taken && !stall;
  endfunction

  task automatic cycle(input logic rst_low, input logic [31:0] irf, pcf, rsd, rtd,
                       input logic rwe, mre, input logic [4:0] wre,
                       input logic mrm, input logic [4:0] wrm);
    exp_t e;
    logic [31:0] npc;
    logic pcsrc, stall;
    @(posedge clk);
    #1;
    reset = !rst_low;
    IR_F = irf; PC4_F = pcf; RS_data = rsd; RT_data = rtd;
    RegWrite_E = rwe; MemToReg_E = mre; WriteReg_E = wre;
    MemToReg_M = mrm; WriteReg_M = wrm;
    if (rst_low) begin
      m_ir = 32'd0; m_pc4 = 32'h00003004; m_sc = 16'd0; m_tc = 16'd0;
    end
    model_eval(m_ir, m_pc4, rsd, rtd, rwe, mre, wre, mrm, wrm, npc, pcsrc, stall);
    e.id = txn_id; e.ir_d = m_ir; e.pc4_d = m_pc4; e.npc = npc;
    e.pcsrc = pcsrc; e.stall = stall; e.sc = m_sc; e.tc = m_tc;
    exp_q.push_back(e);
    txn_id++;
    if (!rst_low) begin
      if (stall) m_sc = m_sc + 16'd1;
      if (pcsrc) m_tc = m_tc + 16'd1;
      if (!stall) begin
`ifdef ID_FLUSH_ON_TAKEN_EN
        m_ir = pcsrc ? 32'd0 : irf;
`else
        m_ir = irf;
`endif
        m_pc4 = pcf;
      end
    end
  endtask

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a decode result; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ir_d", int'(e.id), IR_D, e.ir_d);
        check("pc4_d", int'(e.id), PC4_D, e.pc4_d);
        check("npc", int'(e.id), Npc, e.npc);
        check("pcsrc", int'(e.id), {31'd0, PCSrc}, {31'd0, e.pcsrc});
        check("stall", int'(e.id), {31'd0, Stall}, {31'd0, e.stall});
        check("stall_cnt", int'(e.id), {16'd0, stall_cnt}, {16'd0, e.sc});
        check("taken_cnt", int'(e.id), {16'd0, taken_cnt}, {16'd0, e.tc});
        $display("txn %0d ir_d=%h pc4_d=%h npc=%h pcsrc=%b stall=%b sc=%0d tc=%0d",
                 e.id, IR_D, PC4_D, Npc, PCSrc, Stall, stall_cnt, taken_cnt);
      end
    end
  end

  function automatic logic [31:0] gen_ir();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    tgt = 26'($urandom);
    case ($urandom_range(0, 9))
      0: return {6'b000100, rs, rt, imm};
      1: return {6'b000101, rs, rt, imm};
      2: return {6'b000010, tgt};
      3: return {6'b000011, tgt};
      4: return {6'b000000, rs, 15'd0, 6'b001000};
      5: return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      6: return {6'b100011, rs, rt, imm};
      7: return {6'b101011, rs, rt, imm};
      8: return {6'b001111, rs, rt, imm};
      default: return {6'b001000, rs, rt, imm};
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] a, b;
    int wait_cnt;
    // Directed steps from the bring-up plan.
    cycle(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h10220003, 32'h3008, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h10220003, 32'h300C, 5, 5, 0, 0, 0, 0, 0);
    cycle(0, 32'h14220003, 32'h3010, 5, 6, 0, 0, 0, 0, 0);
    cycle(0, 32'h08000C01, 32'h3014, 5, 6, 0, 0, 0, 0, 0);
    cycle(0, 32'h03E00008, 32'h3018, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h00221820, 32'h301C, 32'h3040, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h00221820, 32'h3020, 32'h3040, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h00221820, 32'h3024, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 32'h00221820, 32'h3024, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 32'h00221820, 32'h3028, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 32'h10220003, 32'h302C, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 32'h0, 32'h3030, 7, 7, 1, 0, 2, 0, 0);
    cycle(0, 32'h0, 32'h3030, 7, 7, 0, 0, 0, 1, 1);
    cycle(0, 32'h0, 32'h3030, 7, 7, 0, 0, 0, 0, 0);
    // Stall held, then reset dropped in the middle of it.
    cycle(0, 32'h00221820, 32'h3034, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 32'h3038, 0, 0, 0, 1, 2, 0, 0);
    cycle(1, 32'h0, 32'h3038, 0, 0, 0, 1, 2, 0, 0);
    cycle(0, 32'h10220003, 32'h3008, 0, 0, 0, 1, 2, 0, 0);
    cycle(0, 32'h12345678, 32'h300C, 9, 9, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 32'h3010, 0, 0, 0, 0, 0, 0, 0);

    // Random instruction streams with small register numbers to provoke hazards.
    pc = 32'h3010;
    for (int i = 0; i < 600; i++) begin
      pc = pc + 32'd4;
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom; b = $urandom;
      end else begin
        a = 32'($urandom_range(0, 2)); b = 32'($urandom_range(0, 2));
      end
      cycle(($urandom_range(0, 99) == 0), gen_ir(), pc, a, b,
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
